// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester round-robin sequencer for a shared saturating 16-bit ALU.
// Define ALU_ARB_FASTPATH_EN to regrant on the response handshake cycle.
module alu_share_arb #(
  parameter int RESET_PRIO  = 0,
  parameter int BUSY_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_ovfl,
  output logic        rsp_zero,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic last, id_q, gnt_id, can_grant, accept, add_ov, sub_ov, ov, err;
  logic [1:0] cnt;
  logic [2:0] op_q;
  logic [3:0] nib_ov;
  logic [15:0] a_q, b_q, add_sat, sub_sat, psa, sll, sra, res;
  logic [16:0] sum, dif;
  assign gnt_id = &req_valid ? ~last : req_valid[1];
`ifdef ALU_ARB_FASTPATH_EN
  assign can_grant = state == IDLE || (state == DONE && rsp_ready);
`else
  assign can_grant = state == IDLE;
`endif
  assign accept = can_grant && |req_valid;
  assign req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign sum = {a_q[15], a_q} + {b_q[15], b_q};
  assign dif = {a_q[15], a_q} - {b_q[15], b_q};
  assign add_ov = sum[16] ^ sum[15];
  assign sub_ov = dif[16] ^ dif[15];
  assign add_sat = add_ov ? {sum[16], {15{~sum[16]}}} : sum[15:0];
  assign sub_sat = sub_ov ? {dif[16], {15{~dif[16]}}} : dif[15:0];
  for (genvar i = 0; i < 4; i++) begin : g_nib
    logic [4:0] s;
    assign s = {a_q[4*i+3], a_q[4*i+:4]} + {b_q[4*i+3], b_q[4*i+:4]};
    assign nib_ov[i] = s[4] ^ s[3];
    assign psa[4*i+:4] = nib_ov[i] ? {s[4], {3{~s[4]}}} : s[3:0];
  end
  assign sll = a_q << b_q[3:0];
  assign sra = 16'($signed(a_q) >>> b_q[3:0]);
  always_comb begin
    res = 16'h0;
    ov = 1'b0;
    err = 1'b0;
    case (op_q)
      3'd0: begin res = add_sat; ov = add_ov; end
      3'd1: begin res = sub_sat; ov = sub_ov; end
      3'd2: begin res = psa; ov = |nib_ov; end
      3'd3: res = sll;
      3'd4: res = sra;
      default: err = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= ~1'(RESET_PRIO);
      cnt <= 2'd0;
      id_q <= 1'b0;
      op_q <= 3'd0;
      a_q <= 16'h0;
      b_q <= 16'h0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= 16'h0;
      rsp_ovfl <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        state <= BUSY;
        last <= gnt_id;
        id_q <= gnt_id;
        op_q <= gnt_id ? req1_op : req0_op;
        a_q <= gnt_id ? req1_a : req0_a;
        b_q <= gnt_id ? req1_b : req0_b;
        cnt <= 2'(BUSY_CYCLES - 1);
      end else if (state == BUSY) begin
        if (cnt == 2'd0) begin
          state <= DONE;
          rsp_valid <= 1'b1;
          rsp_id <= id_q;
          rsp_data <= res;
          rsp_ovfl <= ov;
          rsp_zero <= res == 16'h0;
          rsp_err <= err;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end else if (state == DONE && rsp_ready) begin
        state <= IDLE;
      end
      if (state == DONE && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and randomized checks of alu_share_arb against a behavioural model.
module tb_alu_share_arb;
  localparam int BC = 3;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_valid = 2'b00, req_ready;
  logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
  logic [15:0] req0_a = 16'h0, req0_b = 16'h0, req1_a = 16'h0, req1_b = 16'h0;
  logic rsp_valid, rsp_id, rsp_ovfl, rsp_zero, rsp_err;
  logic [15:0] rsp_data;
  int checks = 0, failures = 0, last = 1, exp_id = 0, waited = 0;
  logic [18:0] exp_rsp;
  typedef struct {int id; logic [2:0] op; logic [15:0] a; logic [15:0] b; logic [18:0] exp;} vec_t;
  vec_t tbl [10] = '{
    '{0, 3'd0, 16'h7FFF, 16'h0001, 19'h27FFF},
    '{1, 3'd1, 16'h8000, 16'h0001, 19'h28000},
    '{1, 3'd1, 16'h1234, 16'h1234, 19'h10000},
    '{0, 3'd2, 16'h7234, 16'h1111, 19'h27345},
    '{1, 3'd2, 16'h1234, 16'h1111, 19'h02345},
    '{0, 3'd4, 16'h8000, 16'h0004, 19'h0F800},
    '{1, 3'd3, 16'h0001, 16'h000F, 19'h08000},
    '{0, 3'd6, 16'h1234, 16'h5678, 19'h50000},
    '{0, 3'd0, 16'h8000, 16'h8000, 19'h28000},
    '{1, 3'd1, 16'h7FFF, 16'hFFFF, 19'h27FFF}};

  always #5 clk = ~clk;

  alu_share_arb #(.RESET_PRIO(0), .BUSY_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovfl(rsp_ovfl), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err));

  function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int r;
    logic ov = 1'b0, er = 1'b0;
    logic [15:0] d = 16'h0;
    case (op)
      3'd0, 3'd1: begin
        r = (op == 3'd0) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
        if (r > 32767) begin r = 32767; ov = 1'b1; end
        else if (r < -32768) begin r = -32768; ov = 1'b1; end
        d = r[15:0];
      end
      3'd2: for (int k = 0; k < 4; k++) begin
        r = int'($signed(a[4*k+:4])) + int'($signed(b[4*k+:4]));
        if (r > 7) begin r = 7; ov = 1'b1; end
        else if (r < -8) begin r = -8; ov = 1'b1; end
        d[4*k+:4] = r[3:0];
      end
      3'd3: d = a << b[3:0];
      3'd4: begin r = int'($signed(a)) >>> b[3:0]; d = r[15:0]; end
      default: er = 1'b1;
    endcase
    return {er, ov, d == 16'h0, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id == 1) begin req1_op = op; req1_a = a; req1_b = b; end
    else begin req0_op = op; req0_a = a; req0_b = b; end
    req_valid[id] = 1'b1;
  endtask

  task automatic set_req(input int id);
    load(id, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
  endtask

  // Waits for the grant predicted by the round-robin rule, then steps past the accept edge.
  task automatic grant(input string tag);
    int n = 0;
    exp_id = (req_valid == 2'b11) ? 1 - last : (req_valid[1] ? 1 : 0);
    @(negedge clk);
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, 32'(req_ready), (exp_id == 1) ? 32'h2 : 32'h1);
    exp_rsp = (exp_id == 1) ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
    last = exp_id;
    waited = n;
    @(posedge clk); #1;
  endtask

  task automatic resp(input string tag);
    int lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!rsp_valid) chk({tag, "_busy_ready"}, 32'(req_ready), 32'h0);
    end while (!rsp_valid && lat < 10);
    chk({tag, "_latency"}, 32'(lat), 32'(BC));
    chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, "_result"}, 32'({rsp_err, rsp_ovfl, rsp_zero, rsp_data}), 32'(exp_rsp));
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] snap;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_ovfl, rsp_zero, rsp_data}), 32'h0);
    chk("reset_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0);
    set_req(1);
    for (int i = 0; i < 4; i++) begin
      grant("rr");
      chk("rr_order", 32'(exp_id), 32'(i % 2));
      set_req(exp_id);
      resp("rr");
    end
    req_valid = 2'b00;
    foreach (tbl[i]) begin
      load(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b);
      grant("dir");
      req_valid = 2'b00;
      exp_rsp = tbl[i].exp;
      resp("dir");
    end
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) if (!req_valid[r] && $urandom_range(0, 1) == 1) set_req(r);
      if (req_valid == 2'b00) set_req(int'($urandom_range(0, 1)));
      grant("rnd");
      req_valid[exp_id] = 1'b0;
      resp("rnd");
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    set_req(0);
    grant("bp");
    set_req(0);
    resp("bp");
    snap = {rsp_id, rsp_err, rsp_ovfl, rsp_zero, rsp_data};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_err, rsp_ovfl, rsp_zero, rsp_data}), 32'({1'b1, snap}));
      chk("bp_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
`ifdef ALU_ARB_FASTPATH_EN
    chk("bp_fast_grant", 32'(req_ready), 32'h1);
    exp_id = 0;
    last = 0;
    exp_rsp = model(req0_op, req0_a, req0_b);
    @(posedge clk); #1;
    req_valid = 2'b00;
    resp("bp_next");
`else
    chk("bp_no_grant", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    grant("bp_next");
    chk("bp_grant_delay", 32'(waited), 32'h0);
    req_valid = 2'b00;
    resp("bp_next");
`endif
    set_req(0);
    grant("rst");
    set_req(0);
    set_req(1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last = 1;
    #1;
    chk("rst_no_stale", 32'(rsp_valid), 32'h0);
    grant("rst_first");
    chk("rst_first_id", 32'(exp_id), 32'h0);
    req_valid = 2'b00;
    resp("rst_first");
    repeat (3) begin
      @(negedge clk);
      chk("rst_quiet", 32'(rsp_valid), 32'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
